// File: rtl/snn_feeder.sv
// snn_feeder: holds host-loaded image/kernel/weight bytes and streams one
// 72-beat frame into the SNN, then waits for its result (or a timeout) and
// reports result, latency and error status back to the host.
module snn_feeder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [6:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        start,
  input  logic        cfg_cg_en,
  output logic        cg_en,
  output logic        in_valid,
  output logic [7:0]  img,
  output logic [7:0]  ker,
  output logic [7:0]  weight,
  input  logic        out_valid,
  input  logic [9:0]  out_data,
  output logic        busy,
  output logic        done,
  output logic [9:0]  result,
  output logic [10:0] latency,
  output logic        timeout,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [6:0]  LAST_K      = 7'd71;
  localparam logic [10:0] TIMEOUT_CNT = 11'd999;  // 1000th WAIT cycle
  localparam logic [10:0] LAT_MAX     = 11'd2047;

  state_t      state_r, state_next_s;
  logic [6:0]  k_r, k_next_s;
  logic [10:0] lat_cnt_r;

  logic [7:0]  img_buf_r    [72];
  logic [7:0]  ker_buf_r    [9];
  logic [7:0]  weight_buf_r [4];

  logic        in_valid_s, busy_s, done_s;
  logic [7:0]  img_s, ker_s, weight_s;

  logic        start_acc_s;
  logic        timeout_hit_s;

  assign start_acc_s   = (state_r == ST_IDLE) && start;
  assign timeout_hit_s = (state_r == ST_WAIT) && !out_valid && (lat_cnt_r == TIMEOUT_CNT);

  // Host write port into the frame buffers; only accepted while idle and in range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 72; i++) img_buf_r[i]    <= 8'd0;
      for (int i = 0; i < 9;  i++) ker_buf_r[i]    <= 8'd0;
      for (int i = 0; i < 4;  i++) weight_buf_r[i] <= 8'd0;
    end else if (wr_en && (state_r == ST_IDLE)) begin
      case (wr_sel)
        2'd0:    if (wr_addr < 7'd72) img_buf_r[wr_addr]          <= wr_data;
        2'd1:    if (wr_addr < 7'd9)  ker_buf_r[wr_addr[3:0]]     <= wr_data;
        2'd2:    if (wr_addr < 7'd4)  weight_buf_r[wr_addr[1:0]]  <= wr_data;
        default: ;
      endcase
    end
  end

  // FSM state and beat-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      k_r     <= 7'd0;
    end else begin
      state_r <= state_next_s;
      k_r     <= k_next_s;
    end
  end

  // Next-state and next-beat decode.
  always_comb begin
    state_next_s = state_r;
    k_next_s     = k_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_SEND;
          k_next_s     = 7'd0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (k_r == LAST_K) begin
          state_next_s = ST_WAIT;
          k_next_s     = 7'd0;
        end else begin
          k_next_s     = k_r + 7'd1;
        end
      end
      ST_WAIT: begin
        if (out_valid || (lat_cnt_r == TIMEOUT_CNT)) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: begin
        state_next_s = ST_IDLE;
        k_next_s     = 7'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so the stream outputs can be registered.
  always_comb begin
    in_valid_s = 1'b0;
    img_s      = 8'd0;
    ker_s      = 8'd0;
    weight_s   = 8'd0;
    busy_s     = (state_next_s != ST_IDLE);
    done_s     = (state_next_s == ST_DONE);
    if (state_next_s == ST_SEND) begin
      in_valid_s = 1'b1;
      img_s      = img_buf_r[k_next_s];
      ker_s      = (k_next_s < 7'd9) ? ker_buf_r[k_next_s[3:0]]    : 8'd0;
      weight_s   = (k_next_s < 7'd4) ? weight_buf_r[k_next_s[1:0]] : 8'd0;
    end else begin
      in_valid_s = 1'b0;
    end
  end

  // Registered SNN-facing and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid <= 1'b0;
      img      <= 8'd0;
      ker      <= 8'd0;
      weight   <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      in_valid <= in_valid_s;
      img      <= img_s;
      ker      <= ker_s;
      weight   <= weight_s;
      busy     <= busy_s;
      done     <= done_s;
    end
  end

  // Response latency counter: cleared while sending, saturating count while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt_r <= 11'd0;
    end else if (state_r == ST_SEND) begin
      lat_cnt_r <= 11'd0;
    end else if ((state_r == ST_WAIT) && !out_valid && (lat_cnt_r != LAT_MAX)) begin
      lat_cnt_r <= lat_cnt_r + 11'd1;
    end else begin
      lat_cnt_r <= lat_cnt_r;
    end
  end

  // Frame status: cleared on accepted start, captured in WAIT, held until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cg_en   <= 1'b0;
      result  <= 10'd0;
      latency <= 11'd0;
      timeout <= 1'b0;
      err     <= 1'b0;
    end else if (start_acc_s) begin
      cg_en   <= cfg_cg_en;
      result  <= 10'd0;
      latency <= 11'd0;
      timeout <= 1'b0;
      err     <= 1'b0;
    end else if ((state_r == ST_SEND) && out_valid) begin
      err     <= 1'b1;
    end else if ((state_r == ST_WAIT) && out_valid) begin
      result  <= out_data;
      latency <= lat_cnt_r + 11'd1;
    end else if (timeout_hit_s) begin
      result  <= 10'd0;
      latency <= lat_cnt_r + 11'd1;
      timeout <= 1'b1;
    end else begin
      err     <= err;
    end
  end

endmodule
